// File: rtl/cipher_lock_if.sv
// Keypad-to-lock bus: key pulses in, lock status and display data out.
interface cipher_lock_if;
  logic        key_en;
  logic [3:0]  key_num;
  logic        unlocked;
  logic        alarm;
  logic        set_mode;
  logic [1:0]  err_cnt;
  logic [15:0] disp_data;
  logic [2:0]  disp_cnt;
  logic [1:0]  state;

  modport master (
    output key_en, key_num,
    input  unlocked, alarm, set_mode, err_cnt, disp_data, disp_cnt, state
  );

  modport slave (
    input  key_en, key_num,
    output unlocked, alarm, set_mode, err_cnt, disp_data, disp_cnt, state
  );
endinterface

// File: rtl/cipher_lock_ctrl.sv
// Password-lock controller: collects 4 digits, unlocks on match, supports password change,
// and enters a timed alarm lockout after MAX_ERR consecutive failures.
module cipher_lock_ctrl #(
  parameter logic [15:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned MAX_ERR     = 3,
  parameter int unsigned LOCK_CYCLES = 100_000_000
) (
  input logic          clk,
  input logic          reset,
  cipher_lock_if.slave bus
);

  typedef enum logic [1:0] {
    StLocked   = 2'd0,
    StUnlocked = 2'd1,
    StSet      = 2'd2,
    StAlarm    = 2'd3
  } state_e;

  localparam logic [1:0]  MaxErr   = 2'(MAX_ERR);
  localparam logic [26:0] LockLoad = 27'(LOCK_CYCLES - 1);
  localparam logic [3:0]  KeyA     = 4'ha;
  localparam logic [3:0]  KeyStar  = 4'he;
  localparam logic [3:0]  KeyHash  = 4'hf;

  // Key inputs are registered first, giving the one-cycle input-to-output latency.
  logic        r_key_en;
  logic [3:0]  r_key_num;
  state_e      r_state,     w_state;
  logic [15:0] r_pw,        w_pw;
  logic [15:0] r_disp_data, w_disp_data;
  logic [2:0]  r_disp_cnt,  w_disp_cnt;
  logic [1:0]  r_err_cnt,   w_err_cnt;
  logic [26:0] r_timer,     w_timer;

  logic w_is_digit;
  logic w_can_shift;
  logic w_full;

  assign w_is_digit  = (r_key_num <= 4'd9);
  assign w_full      = (r_disp_cnt == 3'd4);
  assign w_can_shift = r_key_en && w_is_digit && !w_full;

  // State and input registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_en    <= 1'b0;
      r_key_num   <= 4'd0;
      r_state     <= StLocked;
      r_pw        <= DEFAULT_PW;
      r_disp_data <= 16'd0;
      r_disp_cnt  <= 3'd0;
      r_err_cnt   <= 2'd0;
      r_timer     <= 27'd0;
    end else begin
      r_key_en    <= bus.key_en;
      r_key_num   <= bus.key_num;
      r_state     <= w_state;
      r_pw        <= w_pw;
      r_disp_data <= w_disp_data;
      r_disp_cnt  <= w_disp_cnt;
      r_err_cnt   <= w_err_cnt;
      r_timer     <= w_timer;
    end
  end

  // Next-state logic: digit entry, code check, password change and alarm countdown.
  always_comb begin
    w_state     = r_state;
    w_pw        = r_pw;
    w_disp_data = r_disp_data;
    w_disp_cnt  = r_disp_cnt;
    w_err_cnt   = r_err_cnt;
    w_timer     = r_timer;

    unique case (r_state)
      StLocked: begin
        if (w_can_shift) begin
          w_disp_data = {r_disp_data[11:0], r_key_num};
          w_disp_cnt  = r_disp_cnt + 3'd1;
        end else if (r_key_en && r_key_num == KeyStar) begin
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
        end else if (r_key_en && r_key_num == KeyHash) begin
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
          if (w_full && r_disp_data == r_pw) begin
            w_state   = StUnlocked;
            w_err_cnt = 2'd0;
          end else begin
            w_err_cnt = r_err_cnt + 2'd1;
            if (r_err_cnt + 2'd1 == MaxErr) begin
              w_state = StAlarm;
              w_timer = LockLoad;
            end
          end
        end
      end
      StUnlocked: begin
        if (r_key_en && r_key_num == KeyA) begin
          w_state     = StSet;
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
        end else if (r_key_en && r_key_num == KeyStar) begin
          w_state     = StLocked;
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
        end
      end
      StSet: begin
        if (w_can_shift) begin
          w_disp_data = {r_disp_data[11:0], r_key_num};
          w_disp_cnt  = r_disp_cnt + 3'd1;
        end else if (r_key_en && r_key_num == KeyHash && w_full) begin
          w_pw        = r_disp_data;
          w_state     = StUnlocked;
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
        end else if (r_key_en && r_key_num == KeyStar) begin
          w_state     = StUnlocked;
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
        end
      end
      StAlarm: begin
        // Keys are ignored here, including one landing on the expiry cycle.
        if (r_timer == 27'd0) begin
          w_state     = StLocked;
          w_err_cnt   = 2'd0;
          w_disp_data = 16'd0;
          w_disp_cnt  = 3'd0;
        end else begin
          w_timer = r_timer - 27'd1;
        end
      end
    endcase
  end

  assign bus.state     = r_state;
  assign bus.unlocked  = (r_state == StUnlocked) || (r_state == StSet);
  assign bus.set_mode  = (r_state == StSet);
  assign bus.alarm     = (r_state == StAlarm);
  assign bus.err_cnt   = r_err_cnt;
  assign bus.disp_data = r_disp_data;
  assign bus.disp_cnt  = r_disp_cnt;

endmodule

// File: doc/cipher_lock_ctrl.md
Name: cipher_lock_ctrl

Overview:
- Password-lock controller directly downstream of the 4x4 keypad scanner.
- Consumes the scanner's single-cycle key-press pulse and hex key code. Collects a 4-digit code and compares it against a stored password.
- Supports unlock, re-lock and password change, and enters a timed alarm lockout after repeated failures.
- Outputs drive the LED and 7-segment display stages.

Parameters:
- DEFAULT_PW, 16'h1234: password loaded at reset. 4 BCD nibbles, first-entered digit in [15:12].
- MAX_ERR, 3: consecutive failed attempts that trigger ALARM. Legal range 1..3.
- LOCK_CYCLES, 100_000_000: ALARM duration in clk cycles. Legal range 1..2^27-1; benches use 20.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_en  in  1  one-cycle pulse, one per new key press
- key_num  in  4  key code; valid only while key_en=1 (0-9 digits, a-d, e='*', f='#')
- unlocked  out  1  1 while in UNLOCKED or SET
- alarm  out  1  1 while in ALARM
- set_mode  out  1  1 while in SET
- err_cnt  out  2  consecutive failed attempts
- disp_data  out  16  entered digits, newest in [3:0]
- disp_cnt  out  3  number of digits entered, 0..4
- state  out  2  LOCKED=0, UNLOCKED=1, SET=2, ALARM=3

Behaviour:
- Reset (async):
  - state=LOCKED; pw=DEFAULT_PW.
  - disp_data=0, disp_cnt=0, err_cnt=0, timer=0.
  - unlocked=alarm=set_mode=0.
- Registered outputs; all outputs are decoded from registered state.
- Latency: a key with key_en=1 at edge N is reflected in all outputs after edge N+1. Inputs are ignored when key_en=0.
- Digit entry (LOCKED and SET only):
  - key_num 0-9 with disp_cnt<4: disp_data <= {disp_data[11:0], key_num}; disp_cnt+1.
  - Digit with disp_cnt==4: ignored.
- "Clear" means disp_data=0 and disp_cnt=0.
- Keys a-d: ignored in every state, except 'a' in UNLOCKED.
- LOCKED:
  - 'e': clear.
  - 'f' with disp_cnt==4 and disp_data==pw: go to UNLOCKED, err_cnt=0, clear.
  - 'f' otherwise (wrong code or disp_cnt<4) is a failure: clear and err_cnt+1.
  - If that increment makes err_cnt reach MAX_ERR: go to ALARM, timer=LOCK_CYCLES-1. err_cnt holds MAX_ERR while in ALARM.
- UNLOCKED:
  - 'a': go to SET, clear.
  - 'e': go to LOCKED, clear.
  - Digits and 'f': ignored.
- SET:
  - 'f' with disp_cnt==4: pw<=disp_data, go to UNLOCKED, clear.
  - 'f' with disp_cnt<4: ignored.
  - 'e': abort to UNLOCKED with pw unchanged, clear.
- ALARM:
  - All keys ignored.
  - timer decrements every cycle.
  - The cycle timer==0: go to LOCKED, err_cnt=0, clear.
  - With LOCKS_CYCLES=L, alarm is high for exactly L cycles.
- Timer is 27 bits; no wrap. Timer is only loaded on ALARM entry.
- A key pulse arriving on the same cycle that ALARM expires is ignored.
- Reset mid-operation (any state, including mid-ALARM or mid-SET) restores DEFAULT_PW and LOCKED.
- Consecutive-cycle key_en pulses are each processed. No internal debouncing; debouncing is upstream's responsibility.

Test Plan:
- Unlock: reset, keys 1,2,3,4,f → state=1, unlocked=1, err_cnt=0, disp_cnt=0.
- Overflow digits: keys 1,2,3,4,5 → disp_data=16'h1234, disp_cnt=4. Then f → UNLOCKED.
- Change password: unlock, a, 9,8,7,6, f → state=1. Then e → LOCKED. Then 1,2,3,4,f → err_cnt=1, still LOCKED. Then 9,8,7,6,f → UNLOCKED.
- Short/abort: in SET, keys 5,5,f → stays SET, disp_cnt=2. Then e → UNLOCKED with pw unchanged (1234 still unlocks).
- Alarm (LOCK_CYCLES=20): three wrong codes (0000f ×3) → alarm=1, state=3, err_cnt=3. Key 1,2,3,4,f during alarm → ignored. Alarm is high exactly 20 cycles, then state=0, err_cnt=0.
- Async reset mid-ALARM and after a password change → all outputs 0 next cycle; 1234f unlocks.
